lcd_nibble_controller: RTL and testbench

//  Sequences the HD44780-style character LCD on the board's 4-bit bus (sf_e,e,rs,rw,d,c,b,a).

---
 rtl/lcd_nibble_controller_pkg.sv | 45 ++++
 rtl/lcd_nibble_controller_delay_timer.sv | 36 +++
 rtl/lcd_nibble_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_nibble_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_nibble_controller_pkg.sv
// Shared definitions for the 4-bit HD44780 LCD sequencer: states, command codes,
// default 50 MHz timing and small helpers.
package lcd_nibble_controller_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_SETUP,
        ST_INIT_EHI,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_HI_SETUP,
        ST_HI_EHI,
        ST_GAP,
        ST_LO_SETUP,
        ST_LO_EHI,
        ST_POST_WAIT
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int DEF_SETUP_CYC      = 2;
    localparam int DEF_E_HIGH_CYC     = 12;
    localparam int DEF_NIBBLE_GAP_CYC = 50;
    localparam int DEF_CMD_WAIT_CYC   = 2000;
    localparam int DEF_CLEAR_WAIT_CYC = 82000;
    localparam int DEF_INIT1_WAIT_CYC = 205000;
    localparam int DEF_INIT2_WAIT_CYC = 5000;
    localparam int DEF_POWERUP_CYC    = 750000;

    // Power-on nibble table {3,3,3,2}: three "8-bit mode" wakes, then switch to 4-bit.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Clear and return-home take far longer than every other instruction.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_nibble_controller_delay_timer.sv
// Shared wait timer: a down-counter that loads on request and flags done at zero.
module lcd_nibble_controller_delay_timer #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at zero rather than wrapping; a fresh load restarts it.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_controller.sv
// HD44780 4-bit bus sequencer: power-on init, then byte writes as two timed nibbles
// behind a valid/ready handshake. Write-only, all LCD pins registered.
//
// state      | meaning
// PWRUP      | power-up delay after reset release
// INIT_SETUP | init nibble on bus, e low
// INIT_EHI   | init nibble strobed, e high
// INIT_WAIT  | post-init-nibble delay (table-selected length)
// IDLE       | req_ready high, waiting for a byte
// HI_SETUP   | upper nibble on bus, e low
// HI_EHI     | upper nibble strobed
// GAP        | e low between nibbles
// LO_SETUP   | lower nibble on bus, e low
// LO_EHI     | lower nibble strobed
// POST_WAIT  | instruction execution time
module lcd_nibble_controller
    import lcd_nibble_controller_pkg::*;
#(
    parameter int SETUP_CYC      = DEF_SETUP_CYC,
    parameter int E_HIGH_CYC     = DEF_E_HIGH_CYC,
    parameter int NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
    parameter int CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
    parameter int CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC,
    parameter int INIT1_WAIT_CYC = DEF_INIT1_WAIT_CYC,
    parameter int INIT2_WAIT_CYC = DEF_INIT2_WAIT_CYC,
    parameter int POWERUP_CYC    = DEF_POWERUP_CYC
) (
    input  logic       Clock,
    input  logic       Resetbtn,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic       d,
    output logic       c,
    output logic       b,
    output logic       a
);

    localparam int MAX_CYC = max_int(
        max_int(max_int(SETUP_CYC, E_HIGH_CYC), max_int(NIBBLE_GAP_CYC, CMD_WAIT_CYC)),
        max_int(max_int(CLEAR_WAIT_CYC, INIT1_WAIT_CYC), max_int(INIT2_WAIT_CYC, POWERUP_CYC)));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // A state lasts (load + 1) cycles; zero or negative lengths collapse to one cycle.
    function automatic cnt_t len_to_load(input int n);
        return (n > 0) ? cnt_t'(n - 1) : '0;
    endfunction

    // Setup phases run SETUP_CYC+1 cycles, so e rises SETUP_CYC+1 after the bus changes.
    localparam cnt_t LD_SETUP = cnt_t'(SETUP_CYC);
    localparam cnt_t LD_EHI   = len_to_load(E_HIGH_CYC);
    // The whole e-low span between nibbles is NIBBLE_GAP_CYC, lower-nibble setup included.
    localparam cnt_t LD_GAP   = len_to_load(NIBBLE_GAP_CYC - SETUP_CYC - 1);
    localparam cnt_t LD_CMD   = len_to_load(CMD_WAIT_CYC);
    localparam cnt_t LD_CLEAR = len_to_load(CLEAR_WAIT_CYC);
    localparam cnt_t LD_INIT1 = len_to_load(INIT1_WAIT_CYC);
    localparam cnt_t LD_INIT2 = len_to_load(INIT2_WAIT_CYC);
    localparam cnt_t LD_PWRUP = len_to_load(POWERUP_CYC);

    function automatic cnt_t init_wait_ld(input logic [1:0] idx);
        case (idx)
            2'd0:    return LD_INIT1;
            2'd1:    return LD_INIT2;
            default: return LD_CMD;
        endcase
    endfunction

    lcd_state_e  state_q;
    logic [1:0]  idx_q;
    logic        e_q;
    logic        rs_q;
    logic [3:0]  nib_q;
    logic        ready_q;
    logic        init_done_q;
    logic [7:0]  data_q;

    logic        tmr_load;
    cnt_t        tmr_val;
    logic        tmr_done;

    lcd_nibble_controller_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_PWRUP)
    ) u_timer (
        .clk_i      (Clock),
        .rst_i      (Resetbtn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Timer reload mirrors every FSM transition below, loading the next state's length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_PWRUP, ST_GAP: begin
                tmr_load = tmr_done;
                tmr_val  = LD_SETUP;
            end
            ST_INIT_SETUP, ST_HI_SETUP, ST_LO_SETUP: begin
                tmr_load = tmr_done;
                tmr_val  = LD_EHI;
            end
            ST_INIT_EHI: begin
                tmr_load = tmr_done;
                tmr_val  = init_wait_ld(idx_q);
            end
            ST_INIT_WAIT: begin
                tmr_load = tmr_done && (idx_q != 2'd3);
                tmr_val  = LD_SETUP;
            end
            ST_IDLE: begin
                tmr_load = req_valid && ready_q;
                tmr_val  = LD_SETUP;
            end
            ST_HI_EHI: begin
                tmr_load = tmr_done;
                tmr_val  = LD_GAP;
            end
            ST_LO_EHI: begin
                tmr_load = tmr_done;
                tmr_val  = needs_long_wait(rs_q, data_q) ? LD_CLEAR : LD_CMD;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Resetbtn) begin
        if (Resetbtn) begin
            state_q     <= ST_PWRUP;
            idx_q       <= 2'd0;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            nib_q       <= 4'h0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            case (state_q)
                ST_PWRUP: if (tmr_done) begin
                    state_q <= ST_INIT_SETUP;
                    rs_q    <= 1'b0;
                    nib_q   <= init_nibble(idx_q);
                end
                ST_INIT_SETUP: if (tmr_done) begin
                    state_q <= ST_INIT_EHI;
                    e_q     <= 1'b1;
                end
                ST_INIT_EHI: if (tmr_done) begin
                    state_q <= ST_INIT_WAIT;
                    e_q     <= 1'b0;
                end
                ST_INIT_WAIT: if (tmr_done) begin
                    if (idx_q == 2'd3) begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_INIT_SETUP;
                        idx_q   <= idx_q + 2'd1;
                        nib_q   <= init_nibble(idx_q + 2'd1);
                    end
                end
                ST_IDLE: if (req_valid && ready_q) begin
                    state_q <= ST_HI_SETUP;
                    ready_q <= 1'b0;
                    data_q  <= req_data;
                    rs_q    <= req_rs;
                    nib_q   <= req_data[7:4];
                end
                ST_HI_SETUP: if (tmr_done) begin
                    state_q <= ST_HI_EHI;
                    e_q     <= 1'b1;
                end
                ST_HI_EHI: if (tmr_done) begin
                    state_q <= ST_GAP;
                    e_q     <= 1'b0;
                end
                ST_GAP: if (tmr_done) begin
                    state_q <= ST_LO_SETUP;
                    nib_q   <= data_q[3:0];
                end
                ST_LO_SETUP: if (tmr_done) begin
                    state_q <= ST_LO_EHI;
                    e_q     <= 1'b1;
                end
                ST_LO_EHI: if (tmr_done) begin
                    state_q <= ST_POST_WAIT;
                    e_q     <= 1'b0;
                end
                ST_POST_WAIT: if (tmr_done) begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_PWRUP;
                    e_q     <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sf_e         = 1'b1;
    assign rw           = 1'b0;
    assign e            = e_q;
    assign rs           = rs_q;
    assign {d, c, b, a} = nib_q;
    assign req_ready    = ready_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_lcd_nibble_controller.sv
// Randomized self-checking bench: observed e pulses and ready rises are compared
// against a timeline computed from the LCD timing rules.
module tb_lcd_nibble_controller;

    localparam int S  = 2;
    localparam int EH = 3;
    localparam int GP = 4;
    localparam int CW = 10;
    localparam int CL = 30;
    localparam int I1 = 20;
    localparam int I2 = 15;
    localparam int PU = 50;

    logic       Clock = 1'b0;
    logic       Resetbtn;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       sf_e, e, rs, rw, d, c, b, a;

    lcd_nibble_controller #(
        .SETUP_CYC      (S),
        .E_HIGH_CYC     (EH),
        .NIBBLE_GAP_CYC (GP),
        .CMD_WAIT_CYC   (CW),
        .CLEAR_WAIT_CYC (CL),
        .INIT1_WAIT_CYC (I1),
        .INIT2_WAIT_CYC (I2),
        .POWERUP_CYC    (PU)
    ) dut (
        .Clock     (Clock),
        .Resetbtn  (Resetbtn),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .sf_e      (sf_e),
        .e         (e),
        .rs        (rs),
        .rw        (rw),
        .d         (d),
        .c         (c),
        .b         (b),
        .a         (a)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    typedef struct {
        int         rise;
        int         width;
        logic [3:0] nib;
        logic       rs;
        bit         stable;
        bit         hold;
    } pulse_t;

    typedef struct {
        int         rise;
        logic [3:0] nib;
        logic       rs;
    } exp_t;

    pulse_t obs_q[$];
    int     rdy_obs[$];
    exp_t   exp_q[$];
    int     rdy_exp[$];

    pulse_t cur;
    bit     e_prev    = 1'b0;
    bit     rdy_prev  = 1'b0;
    bit     pins_bad  = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int next_acc_exp = -1;

    always @(negedge Clock) begin
        if (rw !== 1'b0 || sf_e !== 1'b1) pins_bad = 1'b1;
        if (e === 1'b1 && !e_prev) begin
            cur.rise   = cyc;
            cur.nib    = {d, c, b, a};
            cur.rs     = rs;
            cur.stable = 1'b1;
            cur.width  = 0;
            cur.hold   = 1'b0;
        end else if (e === 1'b1 && e_prev) begin
            if ({d, c, b, a} !== cur.nib || rs !== cur.rs) cur.stable = 1'b0;
        end else if (e !== 1'b1 && e_prev) begin
            cur.width = cyc - cur.rise;
            cur.hold  = ({d, c, b, a} === cur.nib) && (rs === cur.rs);
            obs_q.push_back(cur);
        end
        if (req_ready === 1'b1 && !rdy_prev) rdy_obs.push_back(cyc);
        e_prev   = (e === 1'b1);
        rdy_prev = (req_ready === 1'b1);
    end

    task automatic check_eq(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, want, want, cyc);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic push_init_exp(input int rel, output int done_at);
        int         w[4];
        logic [3:0] nibs[4];
        int         rise;
        exp_t       x;
        w    = '{I1, I2, CW, CW};
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        rise = rel + PU + S + 1;
        for (int k = 0; k < 4; k++) begin
            x.rise = rise;
            x.nib  = nibs[k];
            x.rs   = 1'b0;
            exp_q.push_back(x);
            if (k < 3) rise = rise + EH + w[k] + S + 1;
        end
        done_at = rise + EH + w[3];
        rdy_exp.push_back(done_at);
    endtask

    task automatic push_byte_exp(input int acc, input logic r, input logic [7:0] dat,
                                 output int rdy_at);
        exp_t x;
        int   post;
        post = (!r && (dat == 8'h01 || dat == 8'h02 || dat == 8'h03)) ? CL : CW;
        x.rs   = r;
        x.rise = acc + S + 1;
        x.nib  = dat[7:4];
        exp_q.push_back(x);
        x.rise = x.rise + EH + GP;
        x.nib  = dat[3:0];
        exp_q.push_back(x);
        rdy_at = x.rise + EH + post;
        rdy_exp.push_back(rdy_at);
    endtask

    task automatic xfer(input logic r, input logic [7:0] dat, input bit scramble, input bit keep);
        int waited = 0;
        int acc;
        int rdy_at;
        req_valid = 1'b1;
        req_rs    = r;
        req_data  = dat;
        while (req_ready !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        if (waited >= 2000) begin
            check_eq("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (next_acc_exp >= 0) check_eq("accept_cycle", acc, next_acc_exp);
        push_byte_exp(acc, r, dat, rdy_at);
        next_acc_exp = keep ? rdy_at + 1 : -1;
        tick();
        check_eq("ready_drop", int'(req_ready), 0);
        if (scramble) begin
            req_data = 8'($urandom);
            req_rs   = 1'($urandom);
        end
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int last = 0;
        int n    = 0;
        if (rdy_exp.size() > 0) last = rdy_exp[rdy_exp.size() - 1];
        while (cyc < last + 3 && n < 5000) begin
            tick();
            n++;
        end
        check_eq({tag, "_npulses"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check_eq({tag, "_rise"},   obs_q[i].rise,        exp_q[i].rise);
            check_eq({tag, "_width"},  obs_q[i].width,       EH);
            check_eq({tag, "_nib"},    int'(obs_q[i].nib),   int'(exp_q[i].nib));
            check_eq({tag, "_rs"},     int'(obs_q[i].rs),    int'(exp_q[i].rs));
            check_eq({tag, "_stable"}, int'(obs_q[i].stable), 1);
            check_eq({tag, "_hold"},   int'(obs_q[i].hold),  1);
        end
        check_eq({tag, "_nready"}, rdy_obs.size(), rdy_exp.size());
        for (int i = 0; i < rdy_obs.size() && i < rdy_exp.size(); i++)
            check_eq({tag, "_ready_rise"}, rdy_obs[i], rdy_exp[i]);
        obs_q.delete();
        exp_q.delete();
        rdy_obs.delete();
        rdy_exp.delete();
    endtask

    initial begin
        int         rel;
        int         done_at;
        int         n;
        logic [7:0] cmds[4];
        logic [7:0] dat;
        bit         keep;

        cmds      = '{8'h01, 8'h02, 8'h03, 8'h0C};
        Resetbtn  = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) tick();

        check_eq("rst_e",         int'(e),          0);
        check_eq("rst_rs",        int'(rs),         0);
        check_eq("rst_rw",        int'(rw),         0);
        check_eq("rst_nib",       int'({d, c, b, a}), 0);
        check_eq("rst_sf_e",      int'(sf_e),       1);
        check_eq("rst_ready",     int'(req_ready),  0);
        check_eq("rst_init_done", int'(init_done),  0);

        Resetbtn = 1'b0;
        rel = cyc;
        push_init_exp(rel, done_at);
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check_eq("init_done_cycle", cyc, done_at);
        check_eq("ready_with_done", int'(req_ready), 1);
        drain("init");

        xfer(1'b1, 8'h41, 1'b0, 1'b0);
        drain("data41");
        xfer(1'b0, 8'h01, 1'b0, 1'b0);
        drain("clear");
        xfer(1'b0, 8'h0C, 1'b0, 1'b0);
        drain("disp_on");
        xfer(1'b1, 8'h48, 1'b0, 1'b1);
        xfer(1'b1, 8'h49, 1'b0, 1'b0);
        drain("b2b");

        for (int i = 0; i < 25; i++) begin
            dat  = ($urandom_range(0, 2) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
            keep = (i != 24) && ($urandom_range(0, 1) == 1);
            xfer(1'($urandom), dat, 1'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 5)) tick();
        end
        drain("random");

        xfer(1'b1, 8'($urandom), 1'b0, 1'b0);
        n = 0;
        while (e !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_eq("reached_e_high", int'(e), 1);
        Resetbtn = 1'b1;
        #1;
        check_eq("async_rst_e",         int'(e),         0);
        check_eq("async_rst_ready",     int'(req_ready), 0);
        check_eq("async_rst_init_done", int'(init_done), 0);
        repeat (3) tick();
        obs_q.delete();
        exp_q.delete();
        rdy_obs.delete();
        rdy_exp.delete();

        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        Resetbtn  = 1'b0;
        rel = cyc;
        push_init_exp(rel, done_at);
        next_acc_exp = done_at + 1;
        xfer(1'b1, 8'h55, 1'b1, 1'b0);
        drain("reinit_55");

        check_eq("rw_sf_e_constant", int'(pins_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
